// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Build option FETCH_RET_STACK_EN enables the hardware return stack.
package fetch_pkg;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 14;
    localparam int STACK_DEPTH = 4;

    typedef logic [ADDR_W-1:0] pc_t;
    typedef logic [DATA_W-1:0] instr_t;

    localparam pc_t RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; pushes when full and pops when empty are dropped.
// Only instantiated when FETCH_RET_STACK_EN is defined.
module ret_stack
    import fetch_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  pc_t  din,
    output pc_t  dout,
    output logic full,
    output logic empty
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH + 1);

    pc_t           mem [DEPTH];
    logic [SW-1:0] sp;

    assign full  = (sp == SW'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = mem[IW'(sp - SW'(1))];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SW'(1);
        end
    end

    // storage needs no reset: sp alone decides what is live
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IW'(sp)] <= din;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, registers ROM words, handles redirects/halt.
// Build option FETCH_RET_STACK_EN adds the call/return stack.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         halt_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         jump_en,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic [1:0]   state,
    output logic         halted,
    output logic         stack_err
);
    fetch_state_t cur, nxt;
    pc_t  pc, tgt;
    logic active, redirect, fetch, xfer, start_ok;
    logic push, pop, err_set;

    assign active   = (cur == RUN) || (cur == DRAIN);
    assign start_ok = start && ((cur == IDLE) || (cur == HALTED));
    assign xfer     = instr_valid && instr_ready;
    assign rom_addr = pc;
    assign state    = cur;
    assign halted   = (cur == HALTED);

`ifdef FETCH_RET_STACK_EN
    pc_t  stk_top;
    logic stk_full, stk_empty;

    ret_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        redirect = 1'b0;
        tgt      = jump_target;
        push     = 1'b0;
        pop      = 1'b0;
        err_set  = 1'b0;
        if (active) begin
            priority case (1'b1)
                ret_en: begin
                    redirect = 1'b1;
                    pop      = !stk_empty;
                    err_set  = stk_empty;
                    tgt      = stk_empty ? RESET_PC : stk_top;
                end
                call_en: begin
                    redirect = 1'b1;
                    push     = !stk_full;
                    err_set  = stk_full;
                end
                jump_en: redirect = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_err <= 1'b0;
        end else if (start_ok) begin
            stack_err <= 1'b0;
        end else if (err_set) begin
            stack_err <= 1'b1;
        end
    end
`else
    logic unused_ret;

    // without a stack a call is a plain jump and a return is a no-op
    assign unused_ret = ^{ret_en, ret_addr, push, pop, err_set};
    assign redirect   = active && (call_en || jump_en);
    assign tgt        = jump_target;
    assign push       = 1'b0;
    assign pop        = 1'b0;
    assign err_set    = 1'b0;
    assign stack_err  = 1'b0;
`endif

    assign fetch = (cur == RUN) && !redirect
                 && (!instr_valid || instr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:   if (start) nxt = RUN;
            RUN:    if (halt_req) nxt = DRAIN;
            DRAIN:  if (redirect || !instr_valid || instr_ready)
                        nxt = HALTED;
            HALTED: if (start) nxt = RUN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (start_ok) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            // the wrong-path word is dropped even if never accepted
            pc          <= tgt;
            instr_valid <= 1'b0;
        end else if (fetch) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + pc_t'(1);
        end else if (xfer) begin
            instr_valid <= 1'b0;
        end
    end
endmodule
